// File: rtl/baby_load_pkg.sv
// Shared types and constants for the Baby store program loader.
package baby_load_pkg;

  // Bytes shifted into the 8->32 assembler for each store word.
  localparam int unsigned BYTES_PER_WORD = 4;

  // Width of the per-word byte counter (counts 0..BYTES_PER_WORD-1).
  localparam int unsigned BYTE_CNT_W = 2;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StSettle,
    StWrite,
    StDone
  } load_state_e;

endpackage

// File: rtl/baby_load_addr_ctr.sv
// Word address counter for the loader: synchronous clear, increment and a
// last-word flag so the FSM can stop before the counter would wrap.
module baby_load_addr_ctr
  import baby_load_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WORDS  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS - 1);

  logic [ADDR_W-1:0] addr_d, addr_q;

  // Next address: clear has priority over increment.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Address register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == LastAddr);

endmodule

// File: rtl/baby_ram_load_ctrl.sv
// Byte-serial program loader for the Manchester Baby store. Collects bytes
// over valid/ready, pulses the external assembler, and writes each completed
// word to RAM at an auto-incrementing address until the store is full.
module baby_ram_load_ctrl
  import baby_load_pkg::*;
#(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned WORDS          = 32,
  parameter int unsigned BYTES_PER_WORD = baby_load_pkg::BYTES_PER_WORD
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [7:0]        asm_byte_o,
  output logic              asm_shift_o,
  output logic              asm_clr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  input  logic              ram_ack_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [BYTE_CNT_W-1:0] LastByte = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  load_state_e           state_d, state_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_d, byte_cnt_q;
  logic [7:0]            asm_byte_d, asm_byte_q;
  logic                  asm_shift_d, asm_shift_q;
  logic                  asm_clr_d, asm_clr_q;
  logic                  addr_clr, addr_inc, addr_last;

  baby_load_addr_ctr #(
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS)
  ) u_addr_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (addr_clr),
    .inc_i   (addr_inc),
    .addr_o  (ram_addr_o),
    .last_o  (addr_last)
  );

  // Next-state and assembler-control decode; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_byte_d  = asm_byte_q;
    asm_shift_d = 1'b0;
    asm_clr_d   = 1'b0;
    addr_clr    = 1'b0;
    addr_inc    = 1'b0;

    if (abort_i) begin
      state_d    = StIdle;
      asm_clr_d  = 1'b1;
      byte_cnt_d = '0;
      addr_clr   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_d    = StCollect;
            asm_clr_d  = 1'b1;
            byte_cnt_d = '0;
            addr_clr   = 1'b1;
          end
        end
        StCollect: begin
          // Byte is registered now; the shift pulse follows in the next cycle
          // so the assembler sees a byte that has been stable all cycle.
          if (byte_valid_i) begin
            asm_byte_d  = byte_i;
            asm_shift_d = 1'b1;
            byte_cnt_d  = byte_cnt_q + BYTE_CNT_W'(1);
            if (byte_cnt_q == LastByte) begin
              state_d = StSettle;
            end
          end
        end
        StSettle: begin
          // Final shift pulse completes here before the write is requested.
          state_d = StWrite;
        end
        StWrite: begin
          // Last-word check precedes the increment so the counter never wraps.
          if (ram_ack_i) begin
            if (addr_last) begin
              state_d = StDone;
            end else begin
              addr_inc   = 1'b1;
              byte_cnt_d = '0;
              state_d    = StCollect;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and registered assembler controls.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      asm_byte_q  <= '0;
      asm_shift_q <= 1'b0;
      asm_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_byte_q  <= asm_byte_d;
      asm_shift_q <= asm_shift_d;
      asm_clr_q   <= asm_clr_d;
    end
  end

  assign asm_byte_o   = asm_byte_q;
  assign asm_shift_o  = asm_shift_q;
  assign asm_clr_o    = asm_clr_q;
  assign byte_ready_o = (state_q == StCollect);
  assign ram_we_o     = (state_q == StWrite);
  assign done_o       = (state_q == StDone);
  assign busy_o       = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: doc/baby_ram_load_ctrl.md
Name: baby_ram_load_ctrl

Overview:
Sequences byte-serial program loading into the Manchester Baby store. Accepts bytes from the external pin interface over a valid/ready handshake and drives the byte-to-word assembler, whose shift clock pulse and reset it generates. After every 4 bytes it issues one 32-bit RAM write at an auto-incrementing word address. It sits between the Tiny Tapeout input pins and the RAM write port and owns load mode until the store is full or loading is aborted.

Parameters:
ADDR_W, 5, word address width
WORDS, 32, number of store words to load (must be ≤ 2**ADDR_W)
BYTES_PER_WORD, 4, bytes assembled per word (fixed; the assembler is 8→32)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
start_i  in  1  one-cycle pulse; begins a load from address 0
abort_i  in  1  one-cycle pulse; abandons the load and returns to IDLE
byte_i  in  8  incoming byte
byte_valid_i  in  1  byte_i is valid
byte_ready_o  out  1  controller accepts byte this cycle
asm_byte_o  out  8  byte presented to the assembler value input
asm_shift_o  out  1  assembler shift pulse (drives its control/clock input)
asm_clr_o  out  1  assembler reset pulse
ram_addr_o  out  ADDR_W  word address for the write
ram_we_o  out  1  RAM write request, held until acked
ram_ack_i  in  1  RAM has taken the write
busy_o  out  1  load in progress (not IDLE or DONE)
done_o  out  1  all WORDS words written

Behaviour:
- Reset (async): state IDLE; all outputs 0; byte and address counters 0.
- Handshake: a byte is accepted when byte_valid_i && byte_ready_o on a rising clk_i edge. byte_ready_o = 1 only in COLLECT. It is registered-free, i.e. a combinational decode of state.
- States:
  - IDLE: on start_i, assert asm_clr_o for 1 cycle, clear ram_addr_o and the byte counter, and go to COLLECT.
  - COLLECT: each accepted byte is registered into asm_byte_o. asm_shift_o is asserted for exactly the next cycle, so the byte is stable a full cycle before the assembler edge. The byte counter increments. When the 4th byte is accepted, go to SETTLE. Gaps in byte_valid_i are allowed indefinitely.
  - SETTLE: 1 cycle, during which the final asm_shift_o pulse completes. Then go to WRITE.
  - WRITE: ram_we_o = 1 with ram_addr_o stable until ram_ack_i is sampled high.
    - On ack with ram_addr_o == WORDS-1, go to DONE.
    - Otherwise increment ram_addr_o, clear the byte counter, and go to COLLECT.
    - ram_we_o drops in the cycle after the ack.
  - DONE: done_o = 1. start_i restarts the load exactly as from IDLE. abort_i goes to IDLE.
- abort_i in any state: next state is IDLE. ram_we_o, asm_shift_o and byte_ready_o are 0 from the next cycle. asm_clr_o pulses 1 cycle. Address and byte counters are cleared.
- Simultaneous start_i and abort_i: abort wins. start_i outside IDLE and DONE is ignored.
- Byte order: the first byte of a word lands in the assembled word's bits [31:24], the 4th in [7:0] (the assembler shifts left).
- Address wraps never: the load stops at WORDS-1. The ADDR_W counter never overflows when WORDS = 2**ADDR_W, because the DONE check precedes the increment.
- asm_shift_o and asm_clr_o are glitch-free registered outputs; they are never high together.
- busy_o = state ∉ {IDLE, DONE}.

Decomposition:
- Package baby_load_pkg:
  - state enum (IDLE, COLLECT, SETTLE, WRITE, DONE)
  - BYTES_PER_WORD constant
  - byte-counter width constant (2)
- One natural sub-module: baby_load_addr_ctr, which holds the address counter with clear, increment and last-word compare. Everything else stays in the FSM module.
- The existing assembler is instantiated at the top level, not inside this block.

Test Plan:
1. Reset then start_i, feed 0xDE, 0xAD, 0xBE, 0xEF back-to-back, ack after 1 cycle → one write at addr 0; the assembler word reads 0xDEADBEEF; 4 asm_shift_o pulses; ram_we_o high 1 cycle.
2. Same word with ram_ack_i delayed 5 cycles → ram_we_o and ram_addr_o = 0 held for 6 cycles; byte_ready_o = 0 throughout; next bytes go to addr 1.
3. Full load of 32 words with random valid gaps → 32 writes at addresses 0..31 in order; done_o = 1 after the last ack; busy_o = 0; byte_ready_o stays 0 with valid held high.
4. abort_i after 2 bytes of word 3 → IDLE next cycle; asm_clr_o pulses; no write issued; a following start_i loads from addr 0.
5. reset_i asserted mid-WRITE (not synchronised to clk_i) → ram_we_o, busy_o and done_o go 0 immediately; state is IDLE after release.
6. start_i and abort_i in the same cycle from IDLE → remains IDLE; no asm_clr_o from the start path; busy_o = 0.
